router_sync_ctrl: RTL and testbench

- Routing and port-supervision controller between the router FSM and the three output FIFOs of the 1x3 router.
- Latches the 2-bit destination address from the header byte.
- Steers the FSM's single write enable to one FIFO and returns that FIFO's full flag to the FSM.
- Drives per-port valid-out and runs a per-port read-timeout watchdog. The watchdog issues soft resets to the FIFOs and the FSM when a destination leaves its packet unread.

---
 rtl/router_sync_ctrl.sv | 129 ++++++++++++
 tb/tb_router_sync_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_ctrl.sv
// Address latch, write-enable steering and per-port read-timeout watchdog for the 1x3 router.
// Optional ROUTER_TIMEOUT_STATUS_EN adds a sticky per-port timeout status with clear.
module router_sync_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       detect_addr,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
`ifdef ROUTER_TIMEOUT_STATUS_EN
  ,
  input  logic       sts_clr,
  output logic [2:0] timeout_sts
`endif
);

  logic [1:0] addr_reg;
  logic [2:0] vld_vec;
  logic [2:0] rd_vec;
  logic [2:0] soft_reset_vec;

  // 2'b11 is the "no destination" encoding; it is never latched from a header.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_reg <= 2'b11;
    end else if (detect_addr && pkt_valid && (data_in != 2'b11)) begin
      addr_reg <= data_in;
    end
  end

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_reg)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_vec   = {~empty_2, ~empty_1, ~empty_0};
  assign rd_vec    = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0 = vld_vec[0];
  assign vld_out_1 = vld_vec[1];
  assign vld_out_2 = vld_vec[2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_wd
      logic [CNT_W-1:0] cnt_reg;
      logic             soft_reset_reg;
      logic             stall;

      assign stall = vld_vec[gi] && !rd_vec[gi];

      // Counter wraps to zero on the terminal stall cycle so a persisting stall re-arms.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          cnt_reg        <= '0;
          soft_reset_reg <= 1'b0;
        end else if (stall && (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
          cnt_reg        <= '0;
          soft_reset_reg <= 1'b1;
        end else if (stall) begin
          cnt_reg        <= cnt_reg + 1'b1;
          soft_reset_reg <= 1'b0;
        end else begin
          cnt_reg        <= '0;
          soft_reset_reg <= 1'b0;
        end
      end

      assign soft_reset_vec[gi] = soft_reset_reg;
    end
  endgenerate

  assign soft_reset_0 = soft_reset_vec[0];
  assign soft_reset_1 = soft_reset_vec[1];
  assign soft_reset_2 = soft_reset_vec[2];

`ifdef ROUTER_TIMEOUT_STATUS_EN
  logic [2:0] timeout_sts_reg;

  // Set has priority over clear so a pulse coinciding with sts_clr is not lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_sts_reg <= 3'b000;
    end else begin
      timeout_sts_reg <= (sts_clr ? 3'b000 : timeout_sts_reg) | soft_reset_vec;
    end
  end

  assign timeout_sts = timeout_sts_reg;
`endif

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Self-checking bench for router_sync_ctrl: directed test-plan scenarios followed by random traffic
// against a run-length reference model. Define ROUTER_TIMEOUT_STATUS_EN to also cover timeout_sts.
module tb_router_sync_ctrl;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       detect_addr, pkt_valid, write_enb_reg;
  logic [1:0] data_in;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_TIMEOUT_STATUS_EN
  logic       sts_clr;
  logic [2:0] timeout_sts;
`endif

  router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .detect_addr(detect_addr), .pkt_valid(pkt_valid),
    .data_in(data_in), .write_enb_reg(write_enb_reg),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
`ifdef ROUTER_TIMEOUT_STATUS_EN
    , .sts_clr(sts_clr), .timeout_sts(timeout_sts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: latched destination, consecutive-stall run length per port,
  // expected soft-reset pulses and sticky status.
  logic [1:0] exp_addr = 2'b11;
  int         run_len[3] = '{0, 0, 0};
  logic [2:0] exp_sr  = 3'b000;
  logic [2:0] exp_sts = 3'b000;
  int         pulse_cnt[3] = '{0, 0, 0};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    logic [2:0] empt, rd, fl, nsr, exp_we;
    #1;
    empt = {empty_2, empty_1, empty_0};
    rd   = {read_enb_2, read_enb_1, read_enb_0};
    fl   = {full_2, full_1, full_0};
    exp_we = (exp_addr == 2'b11) ? 3'b000 : (3'(write_enb_reg) << exp_addr);
    check_val("write_enb", {5'b0, write_enb}, {5'b0, exp_we});
    check_val("fifo_full", {7'b0, fifo_full}, {7'b0, (exp_addr == 2'b11) ? 1'b0 : fl[exp_addr]});
    check_val("vld_out", {5'b0, vld_out_2, vld_out_1, vld_out_0}, {5'b0, ~empt});
    nsr = 3'b000;
    if (!resetn) begin
      exp_addr = 2'b11;
      exp_sts  = 3'b000;
      for (int i = 0; i < 3; i++) run_len[i] = 0;
    end else begin
      if (detect_addr && pkt_valid && data_in != 2'b11) exp_addr = data_in;
`ifdef ROUTER_TIMEOUT_STATUS_EN
      exp_sts = (sts_clr ? 3'b000 : exp_sts) | exp_sr;
`endif
      for (int i = 0; i < 3; i++) begin
        if (!empt[i] && !rd[i]) begin
          run_len[i]++;
          nsr[i] = (run_len[i] % TIMEOUT) == 0;
        end else begin
          run_len[i] = 0;
        end
      end
    end
    exp_sr = nsr;
    @(posedge clk);
    #1;
    check_val("soft_reset", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, {5'b0, exp_sr});
    for (int i = 0; i < 3; i++) if (exp_sr[i]) pulse_cnt[i]++;
`ifdef ROUTER_TIMEOUT_STATUS_EN
    check_val("timeout_sts", {5'b0, timeout_sts}, {5'b0, exp_sts});
`endif
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int p1_pulses;
    resetn = 1'b0; detect_addr = 1'b0; pkt_valid = 1'b0; data_in = 2'b00;
    write_enb_reg = 1'b1; empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
`ifdef ROUTER_TIMEOUT_STATUS_EN
    sts_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    cycles(2);
    $display("reset: write_enb=%b fifo_full=%b", write_enb, fifo_full);
    resetn = 1'b1; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0; write_enb_reg = 1'b0;

    // Header latch to port 2, then steering and full selection.
    detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 2'b10;
    cycle();
    detect_addr = 1'b0; pkt_valid = 1'b0; write_enb_reg = 1'b1;
    cycle();
    $display("latch addr 2: write_enb=%b", write_enb);
    full_2 = 1'b1;
    cycle();
    full_2 = 1'b0; full_0 = 1'b1;
    cycle();
    $display("full select: fifo_full=%b", fifo_full);
    full_0 = 1'b0;

    // Latch port 1, then an invalid header must not disturb it.
    detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 2'b01; write_enb_reg = 1'b0;
    cycle();
    data_in = 2'b11;
    cycle();
    detect_addr = 1'b0; pkt_valid = 1'b0; write_enb_reg = 1'b1;
    cycle();
    check_val("invalid_hold", {5'b0, write_enb}, 8'h02);
    $display("invalid header: write_enb=%b", write_enb);
    write_enb_reg = 1'b0;

    // Port 1 stall long enough for two pulses.
    pulse_cnt[1] = 0;
    empty_1 = 1'b0;
    cycles(2 * TIMEOUT + 1);
    check_val("p1_pulse_count", 8'(pulse_cnt[1]), 8'd2);
    check_val("p0p2_quiet", 8'(pulse_cnt[0] + pulse_cnt[2]), 8'd0);
    $display("port1 timeout: pulses=%0d", pulse_cnt[1]);
    empty_1 = 1'b1;
    cycle();

    // Port 0 rescued by a read on the would-be terminal cycle.
    pulse_cnt[0] = 0;
    empty_0 = 1'b0;
    cycles(TIMEOUT - 1);
    read_enb_0 = 1'b1;
    cycle();
    read_enb_0 = 1'b0;
    cycles(TIMEOUT - 1);
    check_val("p0_rescued", 8'(pulse_cnt[0]), 8'd0);
    cycle();
    check_val("p0_fresh_fire", 8'(pulse_cnt[0]), 8'd1);
    $display("port0 rescue: pulses=%0d", pulse_cnt[0]);
    empty_0 = 1'b1;
    cycle();

    // Port 2 reset mid-count restarts the full timeout.
    pulse_cnt[2] = 0;
    empty_2 = 1'b0;
    cycles(20);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1; write_enb_reg = 1'b1;
    cycles(TIMEOUT - 1);
    check_val("p2_no_early", 8'(pulse_cnt[2]), 8'd0);
    check_val("addr_after_rst", {5'b0, write_enb}, 8'h00);
    cycle();
    check_val("p2_after_rst", 8'(pulse_cnt[2]), 8'd1);
    $display("port2 reset mid-count: pulses=%0d", pulse_cnt[2]);
    empty_2 = 1'b1; write_enb_reg = 1'b0;
    cycle();

`ifdef ROUTER_TIMEOUT_STATUS_EN
    // Status: set by first pulse, clear coinciding with second pulse is overridden, clear alone works.
    empty_1 = 1'b0;
    p1_pulses = 0;
    for (int k = 0; k < 2 * TIMEOUT + 2; k++) begin
      sts_clr = exp_sr[1] && (p1_pulses == 1);
      if (exp_sr[1]) p1_pulses++;
      cycle();
    end
    sts_clr = 1'b0; empty_1 = 1'b1;
    cycles(2);
    check_val("sts_held", {5'b0, timeout_sts}, 8'h02);
    sts_clr = 1'b1;
    cycle();
    sts_clr = 1'b0;
    check_val("sts_cleared", {5'b0, timeout_sts}, 8'h00);
    $display("status: timeout_sts=%b", timeout_sts);
`else
    p1_pulses = 0;
`endif

    // Random traffic with long-lived empty flags and rare reads so timeouts occur.
    for (int k = 0; k < 1500; k++) begin
      detect_addr   = 1'($urandom_range(0, 1));
      pkt_valid     = 1'($urandom_range(0, 1));
      data_in       = 2'($urandom_range(0, 3));
      write_enb_reg = 1'($urandom_range(0, 1));
      {full_2, full_1, full_0} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) empty_0 = ~empty_0;
      if ($urandom_range(0, 39) == 0) empty_1 = ~empty_1;
      if ($urandom_range(0, 39) == 0) empty_2 = ~empty_2;
      read_enb_0 = ($urandom_range(0, 24) == 0);
      read_enb_1 = ($urandom_range(0, 24) == 0);
      read_enb_2 = ($urandom_range(0, 24) == 0);
      resetn     = ($urandom_range(0, 299) != 0);
`ifdef ROUTER_TIMEOUT_STATUS_EN
      sts_clr    = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end
    $display("random phase: pulses p0=%0d p1=%0d p2=%0d", pulse_cnt[0], pulse_cnt[1], pulse_cnt[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
